branch_resolve_arbiter: RTL and testbench
=========================================

Name: branch_resolve_arbiter

Overview:
- Receives resolved-branch reports from all integer ALU ports and selects the oldest mispredict each cycle.
- Drives the core-wide invalidate (flag plus sequence number) back to every execution unit.
- Issues the frontend PC redirect.
- Holds a flush window, during which an older late mispredict still takes priority over the active flush.

Parameters:
NUM_PORTS, 2, number of ALU branch-report ports
FLUSH_CYCLES, 3, cycles the frontend stall is held after a redirect (min 1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
IN_brValid  in  NUM_PORTS  per-port mispredict report valid
IN_brSqN  in  7*NUM_PORTS  per-port sequence number of the branch
IN_brDst  in  32*NUM_PORTS  per-port correct target PC
IN_comSqN  in  7  sequence number of the oldest uncommitted op (age base)
OUT_invalidate  out  1  flush everything younger than OUT_invalidateSqN
OUT_invalidateSqN  out  7  sqN of the flushing branch
OUT_redirectValid  out  1  one-cycle pulse: frontend loads OUT_redirectPC
OUT_redirectPC  out  32  redirect target
OUT_frontendStall  out  1  high while the flush window is open

Behaviour:
- Age: age(x) = (x - IN_comSqN) mod 128, unsigned 7 bit. Smaller age is older. Equal ages: the lower port index wins.
- Combinational select: pick the oldest valid port.
- A candidate is eligible if state == IDLE, or if age(candidate) < age(activeSqN). Candidates equal to or younger than activeSqN are dropped silently.
- State IDLE, eligible candidate present, at the next edge:
  - activeSqN := candidate sqN
  - OUT_invalidate = 1, OUT_invalidateSqN = sqN
  - OUT_redirectValid = 1, OUT_redirectPC = dst
  - counter := FLUSH_CYCLES
  - state -> FLUSH
- Latency: report in cycle N -> invalidate and redirect visible in N+1.
- State FLUSH:
  - OUT_invalidate is held high for exactly one cycle per accepted report, then drops.
  - OUT_frontendStall = 1 for the whole state. The counter decrements each cycle; state -> IDLE when the counter is 1 and decrementing.
- Older eligible report in FLUSH: re-accept exactly as from IDLE. The new sqN, redirect pulse and invalidate pulse appear, and the counter reloads to FLUSH_CYCLES.
- Simultaneous counter expiry and eligible report: the report wins and the state stays FLUSH.
- IN_comSqN wrap past 127 is handled by the modular age; no special case.
- OUT_redirectValid is a single-cycle pulse. OUT_redirectPC holds its last value otherwise.
- Reset (any time, including mid-flush):
  - OUT_invalidate = 0, OUT_invalidateSqN = 0
  - OUT_redirectValid = 0, OUT_redirectPC = 0
  - OUT_frontendStall = 0
  - state = IDLE, counter = 0
  - Reports present during reset are dropped.
- No X on any output after reset.

Optional Feature:
- Macro: BR_ARB_STATS_EN
- Defined:
  - Adds output OUT_mispredCnt (32-bit) counting accepted reports, including overrides. Saturates at 0xFFFFFFFF; reset value 0.
  - Adds output OUT_overrideCnt (16-bit, saturating) counting overrides only.
- Undefined: both ports and all counter logic are absent. All other behaviour is identical.

Test Plan:
- Single report: comSqN=0, port0 valid sqN=5 dst=0x1000 -> next cycle invalidate=1, invSqN=5, redirectValid=1, PC=0x1000. Stall=1 for 3 cycles, then IDLE.
- Two ports same cycle: comSqN=10, port0 sqN=20, port1 sqN=12 -> port1 chosen, invSqN=12.
- Wrap: comSqN=120, port0 sqN=2 (age 10), port1 sqN=125 (age 5) -> invSqN=125.
- Override: in FLUSH with active sqN=30 and comSqN=0, report sqN=25 -> second invalidate pulse with invSqN=25 and counter reload. Then report sqN=40 -> ignored, no pulse.
- Expiry collision: report arrives on the last stall cycle -> state stays FLUSH, stall does not drop.
- Reset mid-flush: rst_n low two cycles after an accept -> all outputs 0 immediately (async), IDLE after release. With BR_ARB_STATS_EN, mispredCnt reads 0.

Source files
------------

// File: rtl/branch_resolve_arbiter.sv
// ---------------------------------------------------------------------------
// branch_resolve_arbiter
//
// This block collects mispredict reports from the integer ALU ports. Each
// cycle it picks the oldest one relative to the commit pointer and drives the
// core-wide invalidate and the frontend redirect. It then holds the frontend
// stalled for a flush window. An older mispredict that arrives during the
// window overrides the active flush. A report that is equal in age to the
// active branch, or younger, is dropped.
//
// Parameters:
//   NUM_PORTS     number of ALU branch-report ports
//   FLUSH_CYCLES  cycles the frontend stall is held after a redirect (>= 1)
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   IN_brValid           per-port mispredict valid
//   IN_brSqN             per-port 7-bit branch sequence number (packed)
//   IN_brDst             per-port 32-bit correct target (packed)
//   IN_comSqN            sequence number of the oldest uncommitted op
//   OUT_invalidate       one-cycle pulse: flush everything younger than
//                        OUT_invalidateSqN
//   OUT_invalidateSqN    sequence number of the flushing branch
//   OUT_redirectValid    one-cycle pulse: frontend loads OUT_redirectPC
//   OUT_redirectPC       redirect target; holds its last value otherwise
//   OUT_frontendStall    high while the flush window is open
//
// Optional feature (macro BR_ARB_STATS_EN):
//   OUT_mispredCnt       saturating count of accepted reports (32-bit)
//   OUT_overrideCnt      saturating count of overrides only (16-bit)
// ---------------------------------------------------------------------------
module branch_resolve_arbiter #(
    parameter int NUM_PORTS    = 2,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_PORTS-1:0]    IN_brValid,
    input  logic [7*NUM_PORTS-1:0]  IN_brSqN,
    input  logic [32*NUM_PORTS-1:0] IN_brDst,
    input  logic [6:0]              IN_comSqN,
    output logic                    OUT_invalidate,
    output logic [6:0]              OUT_invalidateSqN,
    output logic                    OUT_redirectValid,
    output logic [31:0]             OUT_redirectPC,
`ifdef BR_ARB_STATS_EN
    output logic [31:0]             OUT_mispredCnt,
    output logic [15:0]             OUT_overrideCnt,
`endif
    output logic                    OUT_frontendStall
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;

    // The active flushing sqN is the same register as OUT_invalidateSqN.
    logic [6:0] activeAge;
    assign activeAge = OUT_invalidateSqN - IN_comSqN;

    // Oldest-valid selection. The age is a modular distance from the commit
    // pointer, so a wrap of IN_comSqN past 127 needs no special handling.
    logic        selValid;
    logic [6:0]  selSqN;
    logic [6:0]  selAge;
    logic [31:0] selDst;
    logic [6:0]  curAge;

    // NOTE: every variable in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        selValid = 1'b0;
        selSqN   = '0;
        selAge   = '0;
        selDst   = '0;
        curAge   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            curAge = IN_brSqN[i*7 +: 7] - IN_comSqN;
            // A strict compare keeps the lower port index when ages are equal.
            if (IN_brValid[i] && (!selValid || curAge < selAge)) begin
                selValid = 1'b1;
                selSqN   = IN_brSqN[i*7 +: 7];
                selAge   = curAge;
                selDst   = IN_brDst[i*32 +: 32];
            end
        end
    end

    logic accept;
    assign accept = selValid && (state == IDLE || selAge < activeAge);

    // The stall is exactly the FLUSH state, which is already a register.
    assign OUT_frontendStall = (state == FLUSH);

    // NOTE: sequential state uses non-blocking assignments only. This keeps
    // every register sampling pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            counter           <= '0;
            OUT_invalidate    <= 1'b0;
            OUT_invalidateSqN <= '0;
            OUT_redirectValid <= 1'b0;
            OUT_redirectPC    <= '0;
        end else if (accept) begin
            // A fresh accept and an override look identical. An accept also
            // beats a simultaneous counter expiry.
            state             <= FLUSH;
            counter           <= CNT_W'(FLUSH_CYCLES);
            OUT_invalidate    <= 1'b1;
            OUT_invalidateSqN <= selSqN;
            OUT_redirectValid <= 1'b1;
            OUT_redirectPC    <= selDst;
        end else begin
            OUT_invalidate    <= 1'b0;
            OUT_redirectValid <= 1'b0;
            if (state == FLUSH) begin
                if (counter == CNT_W'(1)) begin
                    state   <= IDLE;
                    counter <= '0;
                end else begin
                    counter <= counter - CNT_W'(1);
                end
            end
        end
    end

`ifdef BR_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            OUT_mispredCnt  <= '0;
            OUT_overrideCnt <= '0;
        end else if (accept) begin
            if (OUT_mispredCnt != '1)
                OUT_mispredCnt <= OUT_mispredCnt + 32'd1;
            if (state == FLUSH && OUT_overrideCnt != '1)
                OUT_overrideCnt <= OUT_overrideCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_arbiter.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_arbiter
//
// Directed testbench for branch_resolve_arbiter with NUM_PORTS=2 and
// FLUSH_CYCLES=3. Inputs are driven on the falling edge. Outputs are sampled
// on the falling edge that follows the active rising edge.
// ---------------------------------------------------------------------------
module tb_branch_resolve_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  brValid;
    logic [13:0] brSqN;
    logic [63:0] brDst;
    logic [6:0]  comSqN;
    logic        invalidate;
    logic [6:0]  invalidateSqN;
    logic        redirectValid;
    logic [31:0] redirectPC;
    logic        frontendStall;
`ifdef BR_ARB_STATS_EN
    logic [31:0] mispredCnt;
    logic [15:0] overrideCnt;
`endif

    int errors = 0;
    int checks = 0;

    branch_resolve_arbiter #(
        .NUM_PORTS   (2),
        .FLUSH_CYCLES(3)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .IN_brValid       (brValid),
        .IN_brSqN         (brSqN),
        .IN_brDst         (brDst),
        .IN_comSqN        (comSqN),
        .OUT_invalidate   (invalidate),
        .OUT_invalidateSqN(invalidateSqN),
        .OUT_redirectValid(redirectValid),
        .OUT_redirectPC   (redirectPC),
`ifdef BR_ARB_STATS_EN
        .OUT_mispredCnt   (mispredCnt),
        .OUT_overrideCnt  (overrideCnt),
`endif
        .OUT_frontendStall(frontendStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge after one active edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] v, input logic [6:0] s0, input logic [31:0] d0,
                         input logic [6:0] s1, input logic [31:0] d1);
        brValid = v;
        brSqN   = {s1, s0};
        brDst   = {d1, d0};
    endtask

    task automatic idleInputs();
        drive(2'b00, 7'd0, 32'd0, 7'd0, 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        comSqN = 7'd0;
        idleInputs();

        // Reset state
        @(negedge clk);
        check("rst_inv", 32'(invalidate), 32'd0);
        check("rst_invSqN", 32'(invalidateSqN), 32'd0);
        check("rst_redir", 32'(redirectValid), 32'd0);
        check("rst_pc", redirectPC, 32'd0);
        check("rst_stall", 32'(frontendStall), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single report, then a stall of 3 cycles
        comSqN = 7'd0;
        drive(2'b01, 7'd5, 32'h1000, 7'd0, 32'd0);
        tick();
        check("single_inv", 32'(invalidate), 32'd1);
        check("single_invSqN", 32'(invalidateSqN), 32'd5);
        check("single_redir", 32'(redirectValid), 32'd1);
        check("single_pc", redirectPC, 32'h1000);
        check("single_stall1", 32'(frontendStall), 32'd1);
        idleInputs();
        tick();
        check("single_inv_drop", 32'(invalidate), 32'd0);
        check("single_redir_drop", 32'(redirectValid), 32'd0);
        check("single_pc_hold", redirectPC, 32'h1000);
        check("single_stall2", 32'(frontendStall), 32'd1);
        tick();
        check("single_stall3", 32'(frontendStall), 32'd1);
        tick();
        check("single_idle", 32'(frontendStall), 32'd0);

        // Two ports in the same cycle: port1 is older
        comSqN = 7'd10;
        drive(2'b11, 7'd20, 32'h2000, 7'd12, 32'h1200);
        tick();
        check("two_invSqN", 32'(invalidateSqN), 32'd12);
        check("two_pc", redirectPC, 32'h1200);
        idleInputs();
        repeat (3) tick();
        check("two_idle", 32'(frontendStall), 32'd0);

        // Wrap: age(2)=10 and age(125)=5 with comSqN=120
        comSqN = 7'd120;
        drive(2'b11, 7'd2, 32'h0222, 7'd125, 32'h1250);
        tick();
        check("wrap_invSqN", 32'(invalidateSqN), 32'd125);
        check("wrap_pc", redirectPC, 32'h1250);
        idleInputs();
        repeat (3) tick();

        // Equal ages: the lower port index wins
        comSqN = 7'd0;
        drive(2'b11, 7'd7, 32'h7000, 7'd7, 32'h7001);
        tick();
        check("tie_pc", redirectPC, 32'h7000);
        idleInputs();
        repeat (3) tick();
        check("tie_idle", 32'(frontendStall), 32'd0);

        // Override: active 30, then 25 overrides, then 40 is ignored
        comSqN = 7'd0;
        drive(2'b01, 7'd30, 32'h3000, 7'd0, 32'd0);
        tick();
        check("ovr_first_invSqN", 32'(invalidateSqN), 32'd30);
        idleInputs();
        tick();
        drive(2'b10, 7'd0, 32'd0, 7'd25, 32'h2500);
        tick();
        check("ovr_inv", 32'(invalidate), 32'd1);
        check("ovr_invSqN", 32'(invalidateSqN), 32'd25);
        check("ovr_redir", 32'(redirectValid), 32'd1);
        check("ovr_pc", redirectPC, 32'h2500);
        drive(2'b01, 7'd40, 32'h4000, 7'd0, 32'd0);
        tick();
        check("young_inv", 32'(invalidate), 32'd0);
        check("young_redir", 32'(redirectValid), 32'd0);
        check("young_invSqN", 32'(invalidateSqN), 32'd25);
        check("young_pc", redirectPC, 32'h2500);
        drive(2'b01, 7'd25, 32'h5555, 7'd0, 32'd0);
        tick();
        check("equal_age_drop", 32'(invalidate), 32'd0);
        check("ovr_reload_stall", 32'(frontendStall), 32'd1);
        idleInputs();
        tick();
        check("ovr_idle", 32'(frontendStall), 32'd0);

        // Expiry collision: an older report on the last stall cycle
        drive(2'b01, 7'd50, 32'h5000, 7'd0, 32'd0);
        tick();
        idleInputs();
        repeat (2) tick();
        check("exp_last_stall", 32'(frontendStall), 32'd1);
        drive(2'b01, 7'd45, 32'h4500, 7'd0, 32'd0);
        tick();
        check("exp_stall_held", 32'(frontendStall), 32'd1);
        check("exp_inv", 32'(invalidate), 32'd1);
        check("exp_invSqN", 32'(invalidateSqN), 32'd45);
        idleInputs();
        repeat (2) tick();
        check("exp_reload_stall", 32'(frontendStall), 32'd1);
        tick();
        check("exp_idle", 32'(frontendStall), 32'd0);

        // Reset mid-flush
        drive(2'b01, 7'd9, 32'h0900, 7'd0, 32'd0);
        tick();
        idleInputs();
        tick();
`ifdef BR_ARB_STATS_EN
        check("stats_mispred", mispredCnt, 32'd9);
        check("stats_override", 32'(overrideCnt), 32'd2);
`endif
        drive(2'b01, 7'd3, 32'h0300, 7'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mrst_inv", 32'(invalidate), 32'd0);
        check("mrst_invSqN", 32'(invalidateSqN), 32'd0);
        check("mrst_redir", 32'(redirectValid), 32'd0);
        check("mrst_pc", redirectPC, 32'd0);
        check("mrst_stall", 32'(frontendStall), 32'd0);
`ifdef BR_ARB_STATS_EN
        check("mrst_mispred", mispredCnt, 32'd0);
`endif
        tick();
        check("mrst_drop_pc", redirectPC, 32'd0);
        idleInputs();
        rst_n = 1'b1;
        tick();
        check("post_rst_inv", 32'(invalidate), 32'd0);
        check("post_rst_stall", 32'(frontendStall), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
